// File: rtl/minmax_tracker4_pkg.sv
// minmax_tracker4_pkg
// Shared definitions for the min/max tracker:
//   DEF_WIDTH / DEF_CNT_W : default sample and count widths
//   CNT_MAX               : saturation value of the default-width counter
//   state_e               : tracker FSM state encoding
//   cmp_t / cmp2()        : 2-bit magnitude compare stage used by mag_cmp4
package minmax_tracker4_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = 4;
  localparam int CNT_MAX   = (1 << DEF_CNT_W) - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_e;

  typedef struct packed {
    logic gt;
    logic lt;
    logic eq;
  } cmp_t;

  function automatic cmp_t cmp2(input logic [1:0] a, input logic [1:0] b);
    cmp_t r;
    r.gt = (a > b);
    r.lt = (a < b);
    r.eq = (a == b);
    return r;
  endfunction

endpackage

// File: rtl/minmax_tracker4_mag_cmp4.sv
// mag_cmp4
// Purely combinational 4-bit unsigned magnitude comparator built from two
// cascaded 2-bit stages: the upper pair decides unless it is equal, in which
// case the lower pair decides.
// Ports:
//   a_i, b_i : operands (unsigned, 4 bits)
//   gt_o     : a_i > b_i
//   lt_o     : a_i < b_i
//   eq_o     : a_i == b_i
module mag_cmp4
  import minmax_tracker4_pkg::*;
(
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic       gt_o,
  output logic       lt_o,
  output logic       eq_o
);

  cmp_t hi;
  cmp_t lo;

  assign hi = cmp2(a_i[3:2], b_i[3:2]);
  assign lo = cmp2(a_i[1:0], b_i[1:0]);

  assign gt_o = hi.gt | (hi.eq & lo.gt);
  assign lt_o = hi.lt | (hi.eq & lo.lt);
  assign eq_o = hi.eq & lo.eq;

endmodule

// File: rtl/minmax_tracker4.sv
// minmax_tracker4
// Framed-stream statistics block. Accepts 4-bit samples over valid/ready,
// tracks running max, min, saturating count and an all-equal flag, and holds
// the result record at end of frame until the consumer takes it.
//
// state | meaning
// ------+-------------------------------------------
// IDLE  | waiting for the first sample of a frame
// ACC   | accumulating samples of the current frame
// HOLD  | result record valid, waiting for out_ready
//
// Ports:
//   clk, rst_n          : clock (rising edge), async active-low reset
//   in_valid/in_ready   : sample handshake; in_ready low only in HOLD
//   in_data, in_last    : sample value and end-of-frame marker
//   out_valid/out_ready : result handshake; out_valid high only in HOLD
//   out_max, out_min    : frame maximum / minimum
//   out_count, out_sat  : saturating sample count and saturation flag
//   out_eq_all          : every sample in the frame was equal
//
// The comparator is fixed at 4 bits, so WIDTH must stay 4.
module minmax_tracker4
  import minmax_tracker4_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_max,
  output logic [WIDTH-1:0] out_min,
  output logic [CNT_W-1:0] out_count,
  output logic             out_sat,
  output logic             out_eq_all
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] max_q, max_d;
  logic [WIDTH-1:0] min_q, min_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic             eq_q, eq_d;

  logic a_gt, a_lt, a_eq;
  logic b_gt, b_lt, b_eq;
  logic accept;

  mag_cmp4 u_cmp_max (
    .a_i  (in_data),
    .b_i  (max_q),
    .gt_o (a_gt),
    .lt_o (a_lt),
    .eq_o (a_eq)
  );

  mag_cmp4 u_cmp_min (
    .a_i  (in_data),
    .b_i  (min_q),
    .gt_o (b_gt),
    .lt_o (b_lt),
    .eq_o (b_eq)
  );

  assign in_ready  = (state_q != HOLD);
  assign out_valid = (state_q == HOLD);
  assign accept    = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    max_d   = max_q;
    min_d   = min_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    eq_d    = eq_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          max_d   = in_data;
          min_d   = in_data;
          cnt_d   = CNT_W'(1);
          sat_d   = 1'b0;
          eq_d    = 1'b1;
          state_d = in_last ? HOLD : ACC;
        end
      end

      ACC: begin
        if (accept) begin
          // Ties leave the stored extreme untouched.
          if (a_gt) max_d = in_data;
          if (b_lt) min_d = in_data;
          eq_d = eq_q & a_eq & b_eq;
          // Count sticks at its maximum; the flag records the overflow.
          if (cnt_q == CntMax) sat_d = 1'b1;
          else                 cnt_d = cnt_q + CNT_W'(1);
          if (in_last) state_d = HOLD;
        end
      end

      HOLD: begin
        if (out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      max_q   <= '0;
      min_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      eq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      max_q   <= max_d;
      min_q   <= min_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      eq_q    <= eq_d;
    end
  end

  assign out_max    = max_q;
  assign out_min    = min_q;
  assign out_count  = cnt_q;
  assign out_sat    = sat_q;
  assign out_eq_all = eq_q;

  // Unused comparator outcomes: only G of A, L of B and both E are needed.
  logic unused_cmp;
  assign unused_cmp = a_lt ^ b_gt;

endmodule

// File: tb/tb_minmax_tracker4.sv
// tb_minmax_tracker4
// Directed plus randomized stimulus for minmax_tracker4. Expected statistics
// are recomputed from the list of accepted samples of the current frame.
module tb_minmax_tracker4;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_max;
  logic [3:0] out_min;
  logic [3:0] out_count;
  logic       out_sat;
  logic       out_eq_all;

  int n_checks = 0;
  int n_errors = 0;

  logic [3:0] frm[$];

  minmax_tracker4 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_max    (out_max),
    .out_min    (out_min),
    .out_count  (out_count),
    .out_sat    (out_sat),
    .out_eq_all (out_eq_all)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference statistics over the samples accepted so far in a frame.
  task automatic check_stats(input string tag, input logic [3:0] s[$]);
    int mx, mn, n, cnt, sat, eq;
    n  = s.size();
    mx = 0;
    mn = 15;
    eq = 1;
    foreach (s[i]) begin
      if (int'(s[i]) > mx) mx = int'(s[i]);
      if (int'(s[i]) < mn) mn = int'(s[i]);
      if (s[i] != s[0])    eq = 0;
    end
    cnt = (n > 15) ? 15 : n;
    sat = (n > 15) ? 1 : 0;
    check({tag, "_max"},   int'(out_max),    mx);
    check({tag, "_min"},   int'(out_min),    mn);
    check({tag, "_count"}, int'(out_count),  cnt);
    check({tag, "_sat"},   int'(out_sat),    sat);
    check({tag, "_eq"},    int'(out_eq_all), eq);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_in_ready"},  int'(in_ready),   1);
    check({tag, "_out_valid"}, int'(out_valid),  0);
    check({tag, "_max"},       int'(out_max),    0);
    check({tag, "_min"},       int'(out_min),    0);
    check({tag, "_count"},     int'(out_count),  0);
    check({tag, "_sat"},       int'(out_sat),    0);
    check({tag, "_eq"},        int'(out_eq_all), 0);
  endtask

  // Drives frm[] starting just after a falling edge; returns just after the
  // falling edge following the final accept.
  task automatic run_frame(input int gap_max, input bit with_last);
    logic [3:0] seen[$];
    int g;
    for (int i = 0; i < frm.size(); i++) begin
      g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      for (int k = 0; k < g; k++) begin
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
        if (seen.size() > 0) check_stats("gap", seen);
      end
      check("in_ready_acc", int'(in_ready), 1);
      check("out_valid_acc", int'(out_valid), 0);
      in_valid = 1'b1;
      in_data  = frm[i];
      in_last  = with_last && (i == frm.size() - 1);
      @(negedge clk);
      seen.push_back(frm[i]);
      check_stats("run", seen);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (with_last) begin
      check("hold_out_valid", int'(out_valid), 1);
      check("hold_in_ready",  int'(in_ready),  0);
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("hs_out_valid", int'(out_valid), 0);
    check("hs_in_ready",  int'(in_ready),  1);
    check_stats("retained", frm);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 4'h0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    #12;
    check_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset("post_reset");

    // Basic frame, back-to-back.
    frm = '{4'd5, 4'd9, 4'd2, 4'd9};
    run_frame(0, 1'b1);
    check("f1_max", int'(out_max), 9);
    check("f1_min", int'(out_min), 2);
    handshake();

    // Single sample with out_ready held high throughout.
    out_ready = 1'b1;
    frm = '{4'd7};
    run_frame(0, 1'b1);
    check("single_eq", int'(out_eq_all), 1);
    @(negedge clk);
    check("single_valid_1cyc", int'(out_valid), 0);
    check("single_ready_back", int'(in_ready),  1);
    out_ready = 1'b0;

    // Boundary values, both orders.
    frm = '{4'h0, 4'hF};
    run_frame(0, 1'b1);
    handshake();
    frm = '{4'hF, 4'h0};
    run_frame(0, 1'b1);
    check("bnd_max", int'(out_max), 15);
    check("bnd_min", int'(out_min), 0);
    handshake();

    // Saturation: 17 equal samples.
    frm = {};
    for (int i = 0; i < 17; i++) frm.push_back(4'hA);
    run_frame(0, 1'b1);
    check("sat_count", int'(out_count), 15);
    check("sat_flag",  int'(out_sat),   1);
    handshake();

    // Backpressure while in HOLD.
    frm = '{4'd8, 4'd1, 4'd12};
    run_frame(0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 4'h3;
      @(negedge clk);
      check("bp_in_ready",  int'(in_ready),  0);
      check("bp_out_valid", int'(out_valid), 1);
      check_stats("bp", frm);
    end
    in_valid = 1'b0;
    handshake();
    frm = '{4'd4, 4'd4};
    run_frame(0, 1'b1);
    handshake();

    // Asynchronous reset mid-frame.
    frm = '{4'd4, 4'd6};
    run_frame(0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_reset("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    frm = '{4'd1};
    run_frame(0, 1'b1);
    check("after_rst_max", int'(out_max), 1);
    handshake();

    // Randomized frames with gaps and delayed acceptance.
    for (int f = 0; f < 30; f++) begin
      int len, d;
      len = int'($urandom_range(12, 1));
      frm = {};
      for (int i = 0; i < len; i++) frm.push_back(4'($urandom_range(15, 0)));
      run_frame(2, 1'b1);
      d = int'($urandom_range(3, 0));
      for (int k = 0; k < d; k++) begin
        @(negedge clk);
        check("rnd_hold_valid", int'(out_valid), 1);
        check_stats("rnd_hold", frm);
      end
      handshake();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
